// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg -- shared definitions for the flash read arbiter.
//   arb_state_e : FSM state encoding (IDLE, START, WAIT, RESP)
//   ERR_DATA    : all-ones pattern returned on a timed-out read.
//                 The arbiter takes the low DW bits, so DW may be up to 256.
//   AW_DEF, DW_DEF, TIMEOUT_DEF : default parameter values
//   cnt_width() : timeout counter width, clog2(TIMEOUT+1), at least 1 bit
package flash_arb_pkg;

   localparam int AW_DEF      = 24;
   localparam int DW_DEF      = 32;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam logic [255:0] ERR_DATA = '1;

   // TIMEOUT=0 (timeout disabled) still gets a 1-bit counter so that the
   // declaration stays legal.
   function automatic int cnt_width(input int tmo);
      return (tmo > 0) ? $clog2(tmo + 1) : 1;
   endfunction

endpackage

// File: rtl/flash_arb_pick.sv
// flash_arb_pick -- combinational winner select for the two read masters.
//   req[1:0]   : in  -- m1/m0 request lines
//   last_owner : in  -- master served most recently (round-robin state)
//   winner     : out -- 0 = m0, 1 = m1; meaningful only when |req
// One expression serves both builds. Under FLASH_ARB_RR_EN the top feeds the
// real last-owner register. Without it, the top ties last_owner high. m1 then
// always counts as "served last", so m0 wins every tie (fixed priority).
module flash_arb_pick (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       winner
);

   // m1 wins when it is alone, or when both request and m0 was served last.
   assign winner = req[1] & ~(req[0] & last_owner);

endmodule

// File: rtl/flash_rd_arbiter.sv
// flash_rd_arbiter -- two-master arbiter in front of a quad-SPI flash reader.
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   m0_/m1_req, _addr          : read request (held until gnt) and address
//   m0_/m1_gnt                 : one-cycle accept pulse
//   m0_/m1_rvalid, _rdata, _err: one-cycle response; err marks a timeout
//   fr_start, fr_addr          : reader start pulse and address
//   fr_busy, fr_done, fr_data  : reader status, completion pulse, data
//   arb_owner                  : current or most recent owner
// Build option FLASH_ARB_RR_EN: round-robin arbitration. Without it the
// arbiter uses fixed priority, with m0 ahead of m1.
// Timing: a request seen in IDLE gives gnt/fr_start on the next cycle. After
// that, WAIT lasts at most TIMEOUT cycles. fr_done in WAIT gives rvalid on the
// next cycle.
module flash_rd_arbiter import flash_arb_pkg::*; #(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,
   output logic          fr_start,
   output logic [AW-1:0] fr_addr,
   input  logic          fr_busy,
   input  logic          fr_done,
   input  logic [DW-1:0] fr_data,
   output logic          arb_owner
);

   localparam int CW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_SAT = (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;

   arb_state_e    state, state_nxt;
   logic [AW-1:0] addr_q;
   logic          owner_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;
   logic [CW-1:0] cnt, cnt_inc;
   logic          last_owner, winner, take, tmo;

   // A new transaction starts only from IDLE, so there is always one IDLE
   // cycle between RESP and the next START.
   assign take = (state == ST_IDLE) && (m0_req || m1_req) && !fr_busy;

   // cnt holds the number of WAIT cycles already elapsed. The timeout fires
   // in the cycle that brings the count to TIMEOUT. That makes WAIT last
   // exactly TIMEOUT cycles.
   assign cnt_inc = cnt + CW'(1);
   assign tmo     = (TIMEOUT != 0) && (cnt_inc == CNT_SAT);

`ifdef FLASH_ARB_RR_EN
   logic last_owner_q;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)               last_owner_q <= 1'b1;
      else if (state == ST_START) last_owner_q <= owner_q;
   end
   assign last_owner = last_owner_q;
`else
   assign last_owner = 1'b1;
`endif

   flash_arb_pick u_pick (
      .req        ({m1_req, m0_req}),
      .last_owner (last_owner),
      .winner     (winner)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         addr_q  <= '0;
         owner_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         if (take) begin
            owner_q <= winner;
            addr_q  <= winner ? m1_addr : m0_addr;
         end
         if (state == ST_START) cnt <= '0;
         if (state == ST_WAIT) begin
            if (cnt != CNT_SAT) cnt <= cnt_inc;
            // fr_done takes precedence over a coincident timeout.
            if (fr_done) begin
               rdata_q <= fr_data;
               err_q   <= 1'b0;
            end else if (tmo) begin
               rdata_q <= ERR_DATA[DW-1:0];
               err_q   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      fr_start  = 1'b0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      m0_err    = 1'b0;
      m1_err    = 1'b0;
      unique case (state)
         ST_IDLE:  if (take) state_nxt = ST_START;
         ST_START: begin
            state_nxt = ST_WAIT;
            fr_start  = 1'b1;
            m0_gnt    = !owner_q;
            m1_gnt    = owner_q;
         end
         ST_WAIT:  if (fr_done || tmo) state_nxt = ST_RESP;
         ST_RESP: begin
            state_nxt = ST_IDLE;
            if (owner_q) begin
               m1_rvalid = 1'b1;
               m1_rdata  = rdata_q;
               m1_err    = err_q;
            end else begin
               m0_rvalid = 1'b1;
               m0_rdata  = rdata_q;
               m0_err    = err_q;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign fr_addr   = addr_q;
   assign arb_owner = owner_q;

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// tb_flash_rd_arbiter -- directed and randomized checks of flash_rd_arbiter.
// The DUT is built with TIMEOUT=16. Expectations follow the build:
// round-robin when FLASH_ARB_RR_EN is defined, fixed m0-first otherwise.
module tb_flash_rd_arbiter;

   localparam int TMO = 16;
`ifdef FLASH_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        m0_req, m1_req;
   logic [23:0] m0_addr, m1_addr;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        fr_start, fr_busy, fr_done, arb_owner;
   logic [23:0] fr_addr;
   logic [31:0] fr_data;

   int errors = 0;
   int checks = 0;
   int last_m = 1;

   always #5 wb_clk_i = ~wb_clk_i;

   flash_rd_arbiter #(.AW(24), .DW(32), .TIMEOUT(TMO)) dut (
      .wb_clk_i  (wb_clk_i),  .wb_rst_i  (wb_rst_i),
      .m0_req    (m0_req),    .m0_addr   (m0_addr),
      .m0_gnt    (m0_gnt),    .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),  .m0_err    (m0_err),
      .m1_req    (m1_req),    .m1_addr   (m1_addr),
      .m1_gnt    (m1_gnt),    .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),  .m1_err    (m1_err),
      .fr_start  (fr_start),  .fr_addr   (fr_addr),
      .fr_busy   (fr_busy),   .fr_done   (fr_done),
      .fr_data   (fr_data),   .arb_owner (arb_owner)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference rules: on a tie, fixed priority gives m0; round-robin gives
   // whoever was not served last. A lone requester always wins.
   function automatic int pick_m(input logic r0, input logic r1, input int last);
      if (r0 && r1) return RR ? ((last == 0) ? 1 : 0) : 0;
      return r0 ? 0 : 1;
   endfunction

   // WAIT cycles are indexed k = 0.. from WAIT entry (transaction cycle 2).
   // fr_done at WAIT index k < TMO gives a response at cycle k+3. Otherwise
   // the timeout gives a response at cycle TMO+2.
   function automatic bit done_ok(input int k);
      return (k >= 0) && (k < TMO);
   endfunction

   function automatic int resp_cyc(input int k);
      return done_ok(k) ? k + 3 : TMO + 2;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_gnt"},    64'({m0_gnt, m1_gnt}), 64'(0));
      chk({tag, "_rvalid"}, 64'({m0_rvalid, m1_rvalid}), 64'(0));
      chk({tag, "_rdata"},  64'({m0_rdata, m1_rdata}), 64'(0));
      chk({tag, "_err"},    64'({m0_err, m1_err}), 64'(0));
      chk({tag, "_start"},  64'(fr_start), 64'(0));
      chk({tag, "_faddr"},  64'(fr_addr), 64'(0));
      chk({tag, "_owner"},  64'(arb_owner), 64'(0));
   endtask

   task automatic do_reset;
      m0_req = 1'b0; m1_req = 1'b0; fr_done = 1'b0; fr_busy = 1'b0;
      wb_rst_i = 1'b1;
      tick;
      wb_rst_i = 1'b0;
      last_m = 1;
   endtask

   // Called in the IDLE cycle (cycle 0) in which the requests are already
   // driven. The task returns in the IDLE cycle that follows RESP.
   task automatic txn(input int done_k, input logic [31:0] dat, input int exp_w,
                      input int exp_rv, input logic [31:0] exp_d, input logic exp_e);
      logic [23:0] ea;
      ea = (exp_w == 1) ? m1_addr : m0_addr;
      tick;
      chk("gnt_win",  64'((exp_w == 1) ? m1_gnt : m0_gnt), 64'(1));
      chk("gnt_lose", 64'((exp_w == 1) ? m0_gnt : m1_gnt), 64'(0));
      chk("fr_start", 64'(fr_start), 64'(1));
      chk("fr_addr",  64'(fr_addr), 64'(ea));
      chk("owner",    64'(arb_owner), 64'(exp_w));
      if (exp_w == 1) m1_req = 1'b0; else m0_req = 1'b0;
      for (int c = 1; c < exp_rv; c++) begin
         if (c > 1) begin
            chk("wait_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
            chk("wait_start",  64'(fr_start), 64'(0));
            chk("wait_faddr",  64'(fr_addr), 64'(ea));
         end
         fr_done = (c - 2 == done_k);
         fr_data = fr_done ? dat : $urandom;
         tick;
      end
      chk("rvalid_win",  64'((exp_w == 1) ? m1_rvalid : m0_rvalid), 64'(1));
      chk("rdata_win",   64'((exp_w == 1) ? m1_rdata : m0_rdata), 64'(exp_d));
      chk("err_win",     64'((exp_w == 1) ? m1_err : m0_err), 64'(exp_e));
      chk("rvalid_lose", 64'((exp_w == 1) ? m0_rvalid : m1_rvalid), 64'(0));
      chk("rdata_lose",  64'((exp_w == 1) ? m0_rdata : m1_rdata), 64'(0));
      fr_done = (exp_rv - 2 == done_k);
      fr_data = $urandom;
      tick;
      fr_done = 1'b0;
      chk("post_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
      chk("post_start",  64'(fr_start), 64'(0));
      last_m = exp_w;
   endtask

   initial begin
      int w, dk, rv;
      logic [31:0] d;
      m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
      fr_busy = 1'b0; fr_done = 1'b0; fr_data = '0; wb_rst_i = 1'b1;

      // Reset state.
      do_reset;
      check_idle_outputs("reset");

      // Single m0 read: gnt at cycle 1, fr_done at cycle 6, rvalid at cycle 7.
      m0_req = 1'b1; m0_addr = 24'h000100;
      txn(4, 32'hDEADBEEF, 0, 7, 32'hDEADBEEF, 1'b0);

      // Simultaneous requests, twice.
      do_reset;
      m0_req = 1'b1; m0_addr = 24'h000200;
      m1_req = 1'b1; m1_addr = 24'h000300;
      txn(2, 32'h11112222, 0, 5, 32'h11112222, 1'b0);
      m0_req = 1'b1; m0_addr = 24'h000400;
      w = RR ? 1 : 0;
      txn(3, 32'h33334444, w, 6, 32'h33334444, 1'b0);
      w = pick_m(m0_req, m1_req, last_m);
      txn(0, 32'h55556666, w, 3, 32'h55556666, 1'b0);

      // Timeout: fr_done never comes; response 16 WAIT cycles after entry.
      m1_req = 1'b1; m1_addr = 24'h00ABCD;
      txn(-1, 32'h0, 1, TMO + 2, 32'hFFFFFFFF, 1'b1);

      // fr_done in the very cycle the timeout expires: data wins.
      m0_req = 1'b1; m0_addr = 24'h00F00D;
      txn(TMO - 1, 32'hCAFEF00D, 0, TMO + 2, 32'hCAFEF00D, 1'b0);

      // Reader busy for 10 cycles holds off m1.
      fr_busy = 1'b1; m1_req = 1'b1; m1_addr = 24'h123456;
      for (int i = 0; i < 10; i++) begin
         chk("busy_start", 64'(fr_start), 64'(0));
         chk("busy_gnt",   64'(m1_gnt), 64'(0));
         tick;
      end
      chk("busy_start", 64'(fr_start), 64'(0));
      fr_busy = 1'b0;
      txn(1, 32'h0BADBEEF, 1, 4, 32'h0BADBEEF, 1'b0);

      // Reset while in WAIT.
      m0_req = 1'b1; m0_addr = 24'h0FEED0;
      tick;
      chk("rst_gnt", 64'(m0_gnt), 64'(1));
      m0_req = 1'b0;
      tick;
      tick;
      wb_rst_i = 1'b1;
      tick;
      wb_rst_i = 1'b0;
      last_m = 1;
      check_idle_outputs("rst_wait");
      fr_done = 1'b1; fr_data = 32'h77777777;
      for (int i = 0; i < 3; i++) begin
         tick;
         fr_done = 1'b0;
         chk("rst_quiet", 64'({m0_rvalid, m1_rvalid, fr_start}), 64'(0));
      end
      m1_req = 1'b1; m1_addr = 24'h0A0B0C;
      txn(2, 32'h89ABCDEF, 1, 5, 32'h89ABCDEF, 1'b0);

      // Randomized traffic against the reference rules.
      for (int n = 0; n < 30; n++) begin
         if (!m0_req && ($urandom_range(0, 1) == 1)) begin
            m0_req = 1'b1; m0_addr = 24'($urandom);
         end
         if (!m1_req && ($urandom_range(0, 1) == 1)) begin
            m1_req = 1'b1; m1_addr = 24'($urandom);
         end
         if (!m0_req && !m1_req) begin
            if ($urandom_range(0, 1) == 1) begin m0_req = 1'b1; m0_addr = 24'($urandom); end
            else begin m1_req = 1'b1; m1_addr = 24'($urandom); end
         end
         // A stray fr_done in IDLE must be ignored.
         fr_done = ($urandom_range(0, 3) == 0);
         fr_data = $urandom;
         w  = pick_m(m0_req, m1_req, last_m);
         dk = int'($urandom_range(0, TMO + 2)) - 1;
         d  = $urandom;
         rv = resp_cyc(dk);
         txn(dk, d, w, rv, done_ok(dk) ? d : 32'hFFFFFFFF, !done_ok(dk));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flash_rd_arbiter.md
FLASH_RD_ARBITER -- requirements
Module: flash_rd_arbiter

Interface
REQ-001 SHALL have parameter AW, 24, flash byte-address width.
REQ-002 SHALL have parameter DW, 32, read-data width.
REQ-003 SHALL have parameter TIMEOUT, 1024, maximum WAIT cycles before abort; 0 disables the timeout.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports m0_req/m1_req  in  1  read request, held until the matching grant.
REQ-007 SHALL have ports m0_addr/m1_addr  in  AW  request address, stable while req is high.
REQ-008 SHALL have ports m0_gnt/m1_gnt  out  1  one-cycle pulse: request accepted.
REQ-009 SHALL have ports m0_rvalid/m1_rvalid  out  1  one-cycle pulse: rdata/err valid.
REQ-010 SHALL have ports m0_rdata/m1_rdata  out  DW  read data.
REQ-011 SHALL have ports m0_err/m1_err  out  1  timeout flag, qualified by rvalid.
REQ-012 SHALL have port fr_start  out  1  one-cycle start pulse to the quad-SPI flash reader.
REQ-013 SHALL have port fr_addr  out  AW  reader address, held from START until exit from WAIT.
REQ-014 SHALL have port fr_busy  in  1  reader busy.
REQ-015 SHALL have port fr_done  in  1  reader completion pulse.
REQ-016 SHALL have port fr_data  in  DW  reader data, valid with fr_done.
REQ-017 SHALL have port arb_owner  out  1  index of the current or most recent owner.

Function
REQ-018 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-019 IDLE: when any req is high and fr_busy is low, SHALL select a winner, latch its addr and owner, and go to START; otherwise SHALL stay in IDLE.
REQ-020 START: SHALL drive fr_start=1 and the owner's gnt=1 for exactly this cycle, then go to WAIT.
REQ-021 WAIT: on fr_done, SHALL capture fr_data and go to RESP with err=0.
REQ-022 WAIT: when the counter reaches TIMEOUT with no fr_done, SHALL go to RESP with err=1 and rdata all-ones.
REQ-023 RESP: SHALL pulse the owner's rvalid with rdata and err for one cycle, then return to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle 0 -> gnt/fr_start at cycle 1; fr_done at cycle N -> rvalid at cycle N+1.
REQ-025 SHALL spend at least one IDLE cycle between transactions, so there is no back-to-back START.
REQ-026 SHALL ignore fr_done in IDLE, START and RESP.
REQ-027 If fr_done and timeout coincide, fr_done SHALL win with err=0.
REQ-028 The non-owner's gnt, rvalid, rdata and err SHALL be 0; a pending request from it SHALL wait in IDLE.
REQ-029 The timeout counter width SHALL be clog2(TIMEOUT+1); it SHALL clear on START and saturate, never wrap.
REQ-030 Fixed priority (macro absent): m0 SHALL win a simultaneous request.

Reset
REQ-031 wb_rst_i high at a clock edge SHALL force IDLE, clear all pulses, rdata, err and counter to 0, and set arb_owner=0 and last_owner=1.
REQ-032 Reset mid-transaction SHALL abort with no rvalid issued; the reader is reset by the same wb_rst_i.

Configuration
REQ-033 Macro FLASH_ARB_RR_EN defined: arbitration SHALL be round-robin, so a simultaneous request goes to the master not served last; last_owner updates in START.
REQ-034 FLASH_ARB_RR_EN undefined: arbitration SHALL be fixed priority m0 > m1, and no last_owner register is built.

Structure
REQ-035 Package flash_arb_pkg SHALL hold the FSM state encoding, the ERR_DATA all-ones constant, and default AW/DW/TIMEOUT.
REQ-036 Sub-module flash_arb_pick SHALL contain the winner selection (fixed or RR), combinational, inputs req[1:0] and last_owner.

Verification
REQ-037 The bench SHALL cover: m0_req only, addr 0x000100, fr_done at cycle 6 with data 0xDEADBEEF -> m0_gnt cycle 1, fr_addr 0x000100, m0_rvalid cycle 7 with 0xDEADBEEF and err 0.
REQ-038 The bench SHALL cover: m0 and m1 request together, twice -> fixed build: m0, m0 (m1 waits); FLASH_ARB_RR_EN build: m0 then m1.
REQ-039 The bench SHALL cover: TIMEOUT=16 with fr_done never asserted -> rvalid at WAIT cycle 16 with err 1 and rdata 0xFFFFFFFF.
REQ-040 The bench SHALL cover: fr_busy held high 10 cycles with m1_req high -> no fr_start until the cycle after fr_busy falls.
REQ-041 The bench SHALL cover: wb_rst_i pulsed during WAIT -> no rvalid, FSM in IDLE and all outputs 0 next cycle, and a new request then served normally.
REQ-042 The bench SHALL cover: fr_done coinciding with the timeout cycle -> err 0 with the fr_data value returned.
